flash_boot_loader: RTL

Boot-time copy engine sitting directly upstream of the flash read controller. Once started, it walks a contiguous range of flash words, issuing single-word read requests to the controller. Each returned 16-bit word is written into main RAM through a simple write handshake, and completion is reported to the CPU reset/boot sequencer.

---
 rtl/flash_boot_pkg.sv | 29 ++
 rtl/flash_boot_watchdog.sv | 39 +++
 rtl/flash_boot_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/flash_boot_pkg.sv
// flash_boot_pkg: shared constants for the flash boot copy engine.
//   - address/data/index widths (22-bit flash word address, 18-bit RAM address)
//   - default run length and per-read timeout
//   - state encoding for the copy FSM
package flash_boot_pkg;

   localparam int FLASH_AW = 22;
   localparam int RAM_AW   = 18;
   localparam int DATA_W   = 16;
   localparam int IDX_W    = 16;

   localparam logic [IDX_W-1:0] DEF_WORD_COUNT = 16'd1024;
   localparam int               DEF_TIMEOUT    = 4096;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_REQ   = ST_REQ,
      S_WAIT  = ST_WAIT,
      S_WRITE = ST_WRITE,
      S_ERR   = ST_ERR
   } state_e;

endpackage

// File: rtl/flash_boot_watchdog.sv
// flash_boot_watchdog: per-read timeout counter for the boot copy engine.
// Only compiled when FLASH_BOOT_TIMEOUT_EN is defined (it has no user otherwise).
// Ports:
//   clk, rst  - clock, async active-high reset
//   load      - clear the count (entry to a new read request)
//   count     - advance the count (waiting on flash)
//   expire    - high in the TIMEOUT-th counting cycle
`ifdef FLASH_BOOT_TIMEOUT_EN
module flash_boot_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)       cnt_d = '0;
      else if (count) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // cnt_q holds the number of cycles already spent, so the TIMEOUT-th
   // counting cycle sees TIMEOUT-1.
   assign expire = count && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: boot-time copy engine, flash -> RAM.
// Walks WORD_COUNT flash words from FLASH_BASE, issuing one-cycle read
// requests, and writes each returned word to RAM_BASE+index through a
// we/ack handshake. done is sticky until the next accepted start.
// Optional feature macro: FLASH_BOOT_TIMEOUT_EN (per-read watchdog, error flag).
// Ports:
//   clk, rst              - clock, async active-high reset
//   start                 - begins a run when seen in IDLE
//   flash_addr/read       - word address and one-cycle read request
//   flash_data/ready      - read data; a read completes on ready's rising edge
//   ram_addr/data/we/ack  - RAM write, we held until ack
//   busy, done, error     - status (done/error sticky)
module flash_boot_loader
   import flash_boot_pkg::*;
#(
   parameter logic [FLASH_AW-1:0] FLASH_BASE = '0,
   parameter logic [RAM_AW-1:0]   RAM_BASE   = '0,
   parameter logic [IDX_W-1:0]    WORD_COUNT = DEF_WORD_COUNT,
   parameter int                  TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [FLASH_AW-1:0] flash_addr,
   output logic                flash_read,
   input  logic [DATA_W-1:0]   flash_data,
   input  logic                flash_ready,
   output logic [RAM_AW-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_data,
   output logic                ram_we,
   input  logic                ram_ack,
   output logic                busy,
   output logic                done,
   output logic                error
);

   if (WORD_COUNT == '0 || TIMEOUT < 1) begin : g_bad_cfg
      $error("flash_boot_loader: WORD_COUNT must be nonzero and TIMEOUT positive");
   end

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic [IDX_W-1:0]    index_inc;
   logic [FLASH_AW-1:0] flash_addr_q, flash_addr_d;
   logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_data_q, ram_data_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wd_load, wd_count, err_set, err_clr, timeout_hit;

   assign index_inc = index_q + 16'd1;

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      flash_addr_d = flash_addr_q;
      ram_addr_d   = ram_addr_q;
      ram_data_d   = ram_data_q;
      ready_d      = ready_q;
      busy_d       = busy_q;
      done_d       = done_q;
      wd_load      = 1'b0;
      wd_count     = 1'b0;
      err_set      = 1'b0;
      err_clr      = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            state_d      = S_REQ;
            index_d      = '0;
            flash_addr_d = FLASH_BASE;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            err_clr      = 1'b1;
            wd_load      = 1'b1;
         end
         S_REQ: state_d = S_WAIT;
         S_WAIT: begin
            // ready_q only tracks flash_ready while waiting, so a level left
            // high by the previous read cannot masquerade as a new edge.
            ready_d  = flash_ready;
            wd_count = 1'b1;
            if (flash_ready && !ready_q) begin
               state_d    = S_WRITE;
               ram_data_d = flash_data;
               ram_addr_d = RAM_BASE + {2'b00, index_q};
            end else if (timeout_hit) begin
               state_d = S_ERR;
               busy_d  = 1'b0;
               err_set = 1'b1;
            end
         end
         S_WRITE: if (ram_ack) begin
            if (index_q == WORD_COUNT - 16'd1) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d      = S_REQ;
               index_d      = index_inc;
               flash_addr_d = FLASH_BASE + {6'd0, index_inc};
               wd_load      = 1'b1;
            end
         end
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         index_q      <= '0;
         flash_addr_q <= '0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         flash_addr_q <= flash_addr_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef FLASH_BOOT_TIMEOUT_EN
   logic error_q, error_d;

   flash_boot_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .load   (wd_load),
      .count  (wd_count),
      .expire (timeout_hit)
   );

   always_comb begin
      error_d = error_q;
      if (err_clr) error_d = 1'b0;
      if (err_set) error_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) error_q <= 1'b0;
      else     error_q <= error_d;
   end

   assign error = error_q;
`else
   // Without the watchdog WAIT blocks indefinitely; its controls go nowhere.
   logic unused_wd_ctl;
   assign unused_wd_ctl = wd_load ^ wd_count ^ err_set ^ err_clr;
   assign timeout_hit   = 1'b0;
   assign error         = 1'b0;
`endif

   assign flash_read = (state_q == S_REQ);
   assign ram_we     = (state_q == S_WRITE);
   assign flash_addr = flash_addr_q;
   assign ram_addr   = ram_addr_q;
   assign ram_data   = ram_data_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
